// File: rtl/tdc_phase_reverse_decoder.sv
// tdc_phase_reverse_decoder: back-end for a phase-reverse TDC delay line.
// Normalises the stage snapshot polarity, bubble-corrects the thermometer
// code, encodes {laps, fine} and sums 2^LOG2_AVG codes per result.
// Ports:
//   clk, rstb          clock, async active-low reset
//   en                 enable; 0 flushes pipeline/accumulator and idles
//   clr_flags          synchronous clear of sticky flags (a set wins)
//   sample_valid       therm/pol/laps valid this cycle
//   therm              raw stage snapshot, bit 0 = first stage
//   pol                1 = true polarity, 0 = inverted line
//   laps               completed full-line traversals
//   out_ready          consumer accepts out_code
//   out_valid/out_code summed result over valid/ready
//   code_last          most recent single decoded code
//   bubble_err         sticky, a bubble was corrected
//   overflow           sticky, a code was dropped under backpressure
module tdc_phase_reverse_decoder #(
  parameter int unsigned N_STAGES   = 32,
  parameter int unsigned WRAP_BITS  = 3,
  parameter int unsigned LOG2_AVG   = 2,
  localparam int unsigned STAGE_BITS = $clog2(N_STAGES),
  localparam int unsigned CODE_W     = WRAP_BITS + STAGE_BITS,
  localparam int unsigned OUT_W      = CODE_W + LOG2_AVG
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 clr_flags,
  input  logic                 sample_valid,
  input  logic [N_STAGES-1:0]  therm,
  input  logic                 pol,
  input  logic [WRAP_BITS-1:0] laps,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_code,
  output logic [CODE_W-1:0]    code_last,
  output logic                 bubble_err,
  output logic                 overflow
);

  localparam int unsigned ONES_W   = STAGE_BITS + 1;
  localparam int unsigned CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RUN  = 2'd1,
    ACC_HOLD = 2'd2
  } acc_state_e;

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [N_STAGES-1:0]  norm_q;
  logic [WRAP_BITS-1:0] laps_q;

  // Stage 2 registers (code_q doubles as code_last)
  logic                 s2_valid_q;
  logic [CODE_W-1:0]    code_q;

  // Accumulator and flags
  acc_state_e           state_q, state_d;
  logic [OUT_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_code_q, out_code_d;
  logic                 bubble_q, bubble_d;
  logic                 overflow_q, overflow_d;

  logic [N_STAGES-1:0]   corr_c;
  logic [STAGE_BITS-1:0] fine_c;

  // Stage 1: undo the per-measurement polarity inversion
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid_q <= 1'b0;
      norm_q     <= '0;
      laps_q     <= '0;
    end else if (!en) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        norm_q <= therm ^ {N_STAGES{~pol}};
        laps_q <= laps;
      end
    end
  end

  // Three-tap majority bubble filter with the line edges padded 1 below and 0 above
  always_comb begin
    logic [N_STAGES+1:0] ext;
    logic [ONES_W-1:0]   ones;
    ext  = {1'b0, norm_q, 1'b1};
    ones = '0;
    corr_c = '0;
    for (int i = 0; i < int'(N_STAGES); i++) begin
      corr_c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
      ones = ones + ONES_W'(corr_c[i]);
    end
    // A fully filled line saturates to the last stage index
    if (ones >= ONES_W'(N_STAGES)) begin
      fine_c = STAGE_BITS'(N_STAGES - 1);
    end else begin
      fine_c = ones[STAGE_BITS-1:0];
    end
  end

  // Stage 2: register the encoded code
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s2_valid_q <= 1'b0;
      code_q     <= '0;
    end else if (!en) begin
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        code_q <= {laps_q, fine_c};
      end
    end
  end

  // Accumulator state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ACC_IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      bubble_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      bubble_q    <= bubble_d;
      overflow_q  <= overflow_d;
    end
  end

  // Accumulator next-state, result load and sticky flags
  always_comb begin
    logic take;
    logic ovf_set;
    logic bub_set;
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    take        = 1'b0;
    ovf_set     = 1'b0;

    case (state_q)
      ACC_IDLE: begin
        sum_d = '0;
        cnt_d = '0;
        if (en) state_d = ACC_RUN;
      end
      ACC_RUN: begin
        take = s2_valid_q;
      end
      ACC_HOLD: begin
        // A code arriving on the handshake cycle starts the next batch
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC_RUN;
          take        = s2_valid_q;
        end else if (s2_valid_q) begin
          ovf_set = 1'b1;
        end
      end
      default: begin
        state_d = ACC_IDLE;
      end
    endcase

    if (take) begin
      if (cnt_q == CNT_LAST) begin
        out_code_d  = sum_q + OUT_W'(code_q);
        out_valid_d = 1'b1;
        sum_d       = '0;
        cnt_d       = '0;
        state_d     = ACC_HOLD;
      end else begin
        sum_d = sum_q + OUT_W'(code_q);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Disable overrides everything except the held result value
    if (!en) begin
      state_d     = ACC_IDLE;
      out_valid_d = 1'b0;
      sum_d       = '0;
      cnt_d       = '0;
      ovf_set     = 1'b0;
    end

    bub_set    = en & s1_valid_q & (corr_c != norm_q);
    bubble_d   = bub_set | (bubble_q & ~clr_flags);
    overflow_d = ovf_set | (overflow_q & ~clr_flags);
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign code_last  = code_q;
  assign bubble_err = bubble_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tdc_phase_reverse_decoder.sv
// Bench for tdc_phase_reverse_decoder: directed spec scenarios plus random
// traffic, checked against a cycle-level behavioural model and a result queue.
module tb_tdc_phase_reverse_decoder;

  localparam int N   = 32;
  localparam int WB  = 3;
  localparam int LA  = 2;
  localparam int AVG = 1 << LA;
  localparam int CW  = WB + $clog2(N);
  localparam int OW  = CW + LA;

  logic          clk = 1'b0;
  logic          rstb;
  logic          en;
  logic          clr_flags;
  logic          sample_valid;
  logic [N-1:0]  therm;
  logic          pol;
  logic [WB-1:0] laps;
  logic          out_ready;
  logic          out_valid;
  logic [OW-1:0] out_code;
  logic [CW-1:0] code_last;
  logic          bubble_err;
  logic          overflow;

  int n_chk = 0;
  int n_fail = 0;

  tdc_phase_reverse_decoder #(.N_STAGES(N), .WRAP_BITS(WB), .LOG2_AVG(LA)) dut (
    .clk(clk), .rstb(rstb), .en(en), .clr_flags(clr_flags),
    .sample_valid(sample_valid), .therm(therm), .pol(pol), .laps(laps),
    .out_ready(out_ready), .out_valid(out_valid), .out_code(out_code),
    .code_last(code_last), .bubble_err(bubble_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Decoded code straight from the definition: normalise, majority-vote, count, saturate
  function automatic int ref_code(input logic [N-1:0] t, input logic p, input int lp, output bit bub);
    int n[0:N+1];
    int ones;
    int c;
    n[0] = 1;
    n[N+1] = 0;
    for (int i = 0; i < N; i++) n[i+1] = (p ? int'(t[i]) : 1 - int'(t[i]));
    ones = 0;
    bub = 0;
    for (int i = 0; i < N; i++) begin
      c = ((n[i] + n[i+1] + n[i+2]) >= 2) ? 1 : 0;
      ones += c;
      if (c != n[i+1]) bub = 1;
    end
    if (ones > N - 1) ones = N - 1;
    return lp * N + ones;
  endfunction

  // Behavioural model state
  int m_s1v, m_s1code, m_s1bub, m_s2v, m_s2code;
  int m_active, m_ov_valid, m_out, m_sum, m_n, m_code_last, m_bub, m_ovf;
  int exp_q[$];

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m_s1v = 0; m_s1code = 0; m_s1bub = 0; m_s2v = 0; m_s2code = 0;
      m_active = 0; m_ov_valid = 0; m_out = 0; m_sum = 0; m_n = 0;
      m_code_last = 0; m_bub = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      int ovf_set;
      int bub_set;
      bit b;
      ovf_set = 0;
      bub_set = 0;
      if (!en) begin
        m_active = 0; m_ov_valid = 0; m_sum = 0; m_n = 0;
        m_s1v = 0; m_s2v = 0;
      end else begin
        if (!m_active) begin
          m_active = 1;
        end else begin
          if (m_ov_valid && out_ready) m_ov_valid = 0;
          if (m_s2v) begin
            if (m_ov_valid) ovf_set = 1;
            else begin
              m_sum += m_s2code;
              m_n++;
              if (m_n == AVG) begin
                m_out = m_sum; m_ov_valid = 1; exp_q.push_back(m_sum);
                m_sum = 0; m_n = 0;
              end
            end
          end
        end
        m_s2v = m_s1v;
        if (m_s1v) begin
          m_s2code = m_s1code;
          m_code_last = m_s1code;
          bub_set = m_s1bub;
        end
        m_s1v = sample_valid ? 1 : 0;
        if (sample_valid) begin
          m_s1code = ref_code(therm, pol, int'(laps), b);
          m_s1bub = b ? 1 : 0;
        end
      end
      m_bub = (bub_set || (m_bub && !clr_flags)) ? 1 : 0;
      m_ovf = (ovf_set || (m_ovf && !clr_flags)) ? 1 : 0;
    end
  end

  // Monitor: compare registered outputs every cycle, pop a result whenever one is presented
  logic prev_v = 1'b0;
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_ov_valid);
    chk("code_last", code_last, m_code_last);
    chk("bubble_err", bubble_err, m_bub);
    chk("overflow", overflow, m_ovf);
    if (out_valid) chk("out_code_held", out_code, m_out);
    if (!rstb) begin
      chk("rst_out_code", out_code, 0);
    end
    if (rstb && out_valid && (!prev_v || prev_hs)) begin
      if (exp_q.size() == 0) chk("result_unexpected", out_code, -1);
      else chk("result", out_code, exp_q.pop_front());
    end
    prev_v  = rstb ? out_valid : 1'b0;
    prev_hs = out_valid & out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [N-1:0] t, input logic p, input logic [WB-1:0] l);
    sample_valid = 1'b1; therm = t; pol = p; laps = l;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_therm(input logic p);
    int f;
    logic [N-1:0] t;
    f = $urandom_range(0, N);
    t = (f == 0) ? '0 : ({N{1'b1}} >> (N - f));
    if ($urandom_range(0, 3) == 0) t[$urandom_range(0, N - 1)] ^= 1'b1;
    return p ? t : ~t;
  endfunction

  initial begin
    rstb = 1'b0; en = 1'b0; clr_flags = 1'b0; sample_valid = 1'b0;
    therm = '0; pol = 1'b1; laps = '0; out_ready = 1'b1;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; sample_valid = 1'($urandom); therm = N'($urandom);
      pol = 1'($urandom); laps = WB'($urandom); clr_flags = 1'($urandom);
      tick();
    end
    chk("rst_code_last", code_last, 0);
    chk("rst_flags", {bubble_err, overflow, out_valid}, 0);
    sample_valid = 1'b0; clr_flags = 1'b0; en = 1'b1;
    rstb = 1'b1;
    idle(2);

    // True polarity, code 72 x4
    for (int i = 0; i < 4; i++) send(32'h0000_00FF, 1'b1, 3'd2);
    idle(4);
    chk("dir_true_code_last", code_last, 72);
    chk("dir_true_sum", out_code, 288);
    chk("dir_true_bubble", bubble_err, 0);

    // Inverted polarity, then alternating polarity
    for (int i = 0; i < 4; i++) send(32'hFFFF_FF00, 1'b0, 3'd2);
    idle(4);
    chk("dir_inv_code_last", code_last, 72);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) send(32'h0000_00FF, 1'b1, 3'd2);
      else send(32'hFFFF_FF00, 1'b0, 3'd2);
    end
    idle(4);
    chk("dir_alt_sum", out_code, 288);

    // Bubble, clear, saturation
    send(32'h0000_00F7, 1'b1, 3'd0);
    idle(3);
    chk("dir_bubble_code", code_last, 8);
    chk("dir_bubble_set", bubble_err, 1);
    pulse_clr();
    idle(1);
    chk("dir_bubble_clr", bubble_err, 0);
    send(32'hFFFF_FFFF, 1'b1, 3'd7);
    idle(3);
    chk("dir_sat_code", code_last, 255);
    for (int i = 0; i < 2; i++) send(32'h0000_00FF, 1'b1, 3'd2);
    idle(4);

    // Backpressure: hold result, drop two codes, then take a code on the handshake cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h0000_00FF, 1'b1, 3'd2);
    idle(3);
    send(32'h0000_00FF, 1'b1, 3'd1);
    send(32'h0000_00FF, 1'b1, 3'd3);
    idle(3);
    chk("dir_bp_hold", out_code, 288);
    chk("dir_bp_overflow", overflow, 1);
    send(32'h0000_03FF, 1'b1, 3'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h0000_03FF, 1'b1, 3'd0);
    idle(4);
    chk("dir_bp_next_batch", out_code, 40);
    pulse_clr();

    // Flush mid-batch
    for (int i = 0; i < 2; i++) send(32'h0000_0FFF, 1'b1, 3'd1);
    en = 1'b0;
    idle(2);
    en = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(32'h0000_03FF, 1'b1, 3'd0);
    idle(4);
    chk("dir_flush_sum", out_code, 40);

    // Reset mid-batch
    for (int i = 0; i < 2; i++) send(32'h0000_0FFF, 1'b1, 3'd1);
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(32'h0000_00FF, 1'b1, 3'd2);
    idle(4);
    chk("dir_rst_mid_sum", out_code, 288);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic p;
      p = 1'($urandom);
      sample_valid = ($urandom_range(0, 9) < 8);
      pol = p;
      therm = rand_therm(p);
      laps = WB'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      clr_flags = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 49) != 0);
      tick();
    end
    sample_valid = 1'b0; clr_flags = 1'b0; en = 1'b1; out_ready = 1'b1;
    idle(8);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
